// File: rtl/muldiv_seq.sv
// Iterative RV32M-style multiply/divide sequencer: MUL, MULHU, DIVU, REMU
// via shift-add multiply and restoring divide, one bit per cycle.
module muldiv_seq #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Start,
  input  logic [1:0]            Funct,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  input  logic                  Kill,
  output logic                  Busy,
  output logic                  Done,
  output logic [DATA_WIDTH-1:0] Result
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int unsigned   CW       = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);

  logic [1:0]            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [1:0]            funct_q, funct_d;
  // acc holds HI (multiply) or R (divide); lo holds LO or Q; opb holds M or D.
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [DATA_WIDTH-1:0] lo_q, lo_d;
  logic [DATA_WIDTH-1:0] opb_q, opb_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;

  logic [DATA_WIDTH:0]     mul_sum;
  logic [2*DATA_WIDTH-1:0] div_sh;
  logic [DATA_WIDTH-1:0]   div_r, div_q;
  logic [DATA_WIDTH:0]     div_trial;
  logic [DATA_WIDTH-1:0]   it_acc, it_lo;

  always_comb begin
    mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
    div_sh    = {acc_q, lo_q} << 1;
    div_r     = div_sh[2*DATA_WIDTH-1:DATA_WIDTH];
    div_q     = div_sh[DATA_WIDTH-1:0];
    div_trial = {1'b0, div_r} - {1'b0, opb_q};
    if (funct_q[1]) begin
      if (!div_trial[DATA_WIDTH]) begin
        it_acc = div_trial[DATA_WIDTH-1:0];
        it_lo  = div_q | DATA_WIDTH'(1);
      end else begin
        it_acc = div_r;
        it_lo  = div_q;
      end
    end else begin
      it_acc = mul_sum[DATA_WIDTH:1];
      it_lo  = {mul_sum[0], lo_q[DATA_WIDTH-1:1]};
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    funct_d  = funct_q;
    acc_d    = acc_q;
    lo_d     = lo_q;
    opb_d    = opb_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (Start && !Kill) begin
          funct_d = Funct;
          acc_d   = '0;
          lo_d    = Funct[1] ? SrcA : SrcB;
          opb_d   = Funct[1] ? SrcB : SrcA;
          cnt_d   = '0;
          if (Funct[1] && (SrcB == '0)) begin
            state_d  = S_DONE;
            result_d = Funct[0] ? SrcA : '1;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (Kill) begin
          state_d = S_IDLE;
        end else begin
          acc_d = it_acc;
          lo_d  = it_lo;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) begin
            state_d = S_DONE;
            // Funct[0] picks the upper half (HI / remainder) for both op classes.
            result_d = funct_q[0] ? it_acc : it_lo;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      funct_q  <= '0;
      acc_q    <= '0;
      lo_q     <= '0;
      opb_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      funct_q  <= funct_d;
      acc_q    <= acc_d;
      lo_q     <= lo_d;
      opb_q    <= opb_d;
      result_q <= result_d;
    end
  end

  assign Busy   = (state_q == S_RUN);
  assign Done   = (state_q == S_DONE);
  assign Result = result_q;

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Iterative multiply/divide sequencer for the execute stage, working alongside the single-cycle ALU. It runs RV32M-style MUL, MULHU, DIVU and REMU as a shift-add / restoring-divide loop over DATA_WIDTH cycles. Its Busy output stalls the pipeline while an operation runs. The execute-stage mux selects Result in place of ALUResult when Done pulses.

## Interface

Parameters:
- DATA_WIDTH, 32, operand/result width; the iteration count equals DATA_WIDTH.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- Start  in  1  request; sampled only in IDLE.
- Funct  in  2  operation: 00 MUL (low product), 01 MULHU (high product, unsigned), 10 DIVU, 11 REMU.
- SrcA  in  DATA_WIDTH  multiplicand / dividend; sampled with Start.
- SrcB  in  DATA_WIDTH  multiplier / divisor; sampled with Start.
- Kill  in  1  pipeline flush; aborts any operation in progress.
- Busy  out  1  high while in RUN; drives the pipeline stall.
- Done  out  1  one-cycle pulse; Result is valid.
- Result  out  DATA_WIDTH  registered result; holds until the next completion.

## Operation

States and transitions:
- IDLE:
  - If Start=1 and Kill=0, latch Funct, SrcA and SrcB.
  - Divide (Funct[1]=1) with SrcB=0 goes to DONE directly.
  - Any other accepted request goes to RUN and sets the counter to 0.
- RUN:
  - Performs one iteration per cycle.
  - Exits to DONE after the iteration with counter = DATA_WIDTH-1.
  - Kill=1 goes to IDLE; Result is unchanged and there is no Done pulse.
- DONE:
  - Done=1 for exactly one cycle, then unconditionally to IDLE.
  - Start is ignored in DONE.

Multiply datapath:
- Registers: HI = 0, LO = multiplier, M = multiplicand.
- Per iteration: sum = {1'b0,HI} + (LO[0] ? {1'b0,M} : 0), 33 bits.
- Then {HI,LO} <= {sum, LO} >> 1; the carry is kept in the shifted-in MSB.
- On entry to DONE: Result = LO for MUL, HI for MULHU.

Divide datapath (restoring):
- Registers: R = 0, Q = dividend, D = divisor.
- Per iteration: {R',Q'} = {R,Q} << 1, then trial = {1'b0,R'} - {1'b0,D}, 33 bits.
- If trial[32]=0: R <= trial[31:0] and Q <= {Q'[31:1],1}. Otherwise R <= R' and Q <= Q'.
- On entry to DONE: Result = Q for DIVU, R for REMU.

Divide by zero:
- DIVU result = all ones.
- REMU result = dividend.
- No iterations are run.

Other rules:
- All arithmetic is unsigned and modulo 2^DATA_WIDTH; no overflow flag.
- Operands are captured at accept time, so SrcA, SrcB and Funct may change during RUN without effect.

## Timing

- Reset (reset=0 at an edge):
  - state is IDLE.
  - Busy=0, Done=0, Result=0, counter=0.
  - Applies even mid-RUN.
  - reset has priority over Kill and Start.
- Start accepted in cycle c (IDLE, Start=1, Kill=0):
  - Busy=1 in cycles c+1 .. c+DATA_WIDTH (32 cycles).
  - Done=1 and Result valid in cycle c+DATA_WIDTH+1.
  - state is IDLE in cycle c+DATA_WIDTH+2, so a new Start can be accepted there.
- Divide by zero accepted in cycle c: Done=1 in cycle c+1 and Busy never rises.
- Busy is decoded from state (RUN) and Done from state (DONE); no combinational path from Start to Busy.
- Kill in IDLE suppresses acceptance of a simultaneous Start.
- Kill in DONE has no effect: the Done pulse still occurs and Result updates.
- Start while Busy=1 or Done=1 is dropped; the requester must hold Start until it is accepted.

## Test plan

- MUL 7×6, Start at cycle 0 -> Busy high cycles 1–32, Done at cycle 33, Result=0x0000002A. MULHU 0xFFFFFFFF×0xFFFFFFFF -> Result=0xFFFFFFFE; MUL of the same operands -> Result=0x00000001.
- DIVU 100/7 -> Result=14 at cycle 33; REMU 100/7 -> 2; DIVU 0x80000000/1 -> 0x80000000; REMU 5/9 -> 5.
- DIVU 1234/0 -> Done at cycle 1, Result=0xFFFFFFFF, Busy stays 0; REMU 1234/0 -> Result=1234.
- Kill at the 10th RUN cycle of MUL 3×5 -> Busy=0 next cycle, no Done, Result holds its previous value. A following DIVU 9/3 -> Result=3 with normal latency.
- reset=0 mid-RUN -> next cycle Busy=0, Done=0, Result=0. Start held high during RUN with changing SrcA/SrcB -> ignored, and the original result is produced.
- Back-to-back: Start held high continuously -> second operation accepted in the cycle after Done, and both Results are correct.
